psum_accumulator: RTL and testbench

Downstream consumer of the 32-input signed tree adder. Each 16-bit tree-adder sum is one partial sum. This block accumulates NUM_PASS consecutive partial sums plus a bias into one output value, applies optional ReLU, and saturates the result to 16 bits. Finished values are buffered with their write addresses in a small first-word-fall-through (FWFT) FIFO and presented to the memory write-back stage over a valid/ready handshake.

---
 rtl/psum_accumulator.sv | 143 ++++++++++++++
 tb/tb_psum_accumulator.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// Accumulates NUM_PASS signed partial sums plus a bias, applies optional ReLU,
// saturates to DATA_W bits and queues {data, addr} in a small FWFT FIFO.
module psum_accumulator #(
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 24,
  parameter int NUM_PASS   = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     relu_en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_psum,
  input  logic signed [DATA_W-1:0] in_bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0]        out_addr,
  output logic                     busy,
  output logic                     ovf
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [7:0] LAST_PASS = 8'(NUM_PASS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [7:0]               r_pass_cnt;
  logic signed [ACC_W-1:0]  r_acc;
  logic [ADDR_W-1:0]        r_addr_cnt;
  logic                     r_ovf;
  logic signed [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
  logic [ADDR_W-1:0]        r_mem_addr [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wptr;
  logic [PTR_W-1:0]         r_rptr;
  logic [CNT_W-1:0]         r_count;
  logic signed [DATA_W-1:0] r_last_data;
  logic [ADDR_W-1:0]        r_last_addr;

  logic                     w_full;
  logic                     w_empty;
  logic                     w_accept;
  logic                     w_first;
  logic                     w_last;
  logic                     w_push;
  logic                     w_pop;
  logic signed [ACC_W-1:0]  w_psum_ext;
  logic signed [ACC_W-1:0]  w_bias_ext;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_relu;
  logic signed [DATA_W-1:0] w_sat_data;
  logic                     w_sat_hit;

  // in_ready depends only on the registered count, never on out_ready.
  assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  assign in_ready = !w_full && !clear && !reset;
  assign w_accept = in_valid && in_ready;
  assign w_first  = (r_pass_cnt == 8'd0);
  assign w_last   = (r_pass_cnt == LAST_PASS);
  assign w_push   = w_accept && w_last;
  assign w_pop    = !w_empty && out_ready;

  assign w_psum_ext = {{(ACC_W-DATA_W){in_psum[DATA_W-1]}}, in_psum};
  assign w_bias_ext = {{(ACC_W-DATA_W){in_bias[DATA_W-1]}}, in_bias};
  assign w_sum      = (w_first ? w_bias_ext : r_acc) + w_psum_ext;

  always_comb begin
    w_relu     = w_sum;
    w_sat_data = w_sum[DATA_W-1:0];
    w_sat_hit  = 1'b0;
    if (relu_en && w_sum[ACC_W-1]) begin
      w_relu = '0;
    end
    if (w_relu > SAT_MAX) begin
      w_sat_data = {1'b0, {(DATA_W-1){1'b1}}};
      w_sat_hit  = 1'b1;
    end else if (w_relu < SAT_MIN) begin
      w_sat_data = {1'b1, {(DATA_W-1){1'b0}}};
      w_sat_hit  = 1'b1;
    end else begin
      w_sat_data = w_relu[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_pass_cnt  <= '0;
      r_acc       <= '0;
      r_addr_cnt  <= '0;
      r_ovf       <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_last_data <= '0;
      r_last_addr <= '0;
    end else begin
      if (w_accept) begin
        if (w_last) begin
          r_pass_cnt <= '0;
          r_acc      <= '0;
        end else begin
          r_pass_cnt <= r_pass_cnt + 8'd1;
          r_acc      <= w_sum;
        end
      end
      if (w_push) begin
        r_wptr     <= r_wptr + PTR_W'(1);
        r_addr_cnt <= r_addr_cnt + ADDR_W'(1);
        if (w_sat_hit) r_ovf <= 1'b1;
      end
      // The popped head is kept so the outputs hold once the FIFO drains.
      if (w_pop) begin
        r_rptr      <= r_rptr + PTR_W'(1);
        r_last_data <= r_mem_data[r_rptr];
        r_last_addr <= r_mem_addr[r_rptr];
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !reset && !clear) begin
      r_mem_data[r_wptr] <= w_sat_data;
      r_mem_addr[r_wptr] <= r_addr_cnt;
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? r_last_data : r_mem_data[r_rptr];
  assign out_addr  = w_empty ? r_last_addr : r_mem_addr[r_rptr];
  assign busy      = (r_pass_cnt != 8'd0) || !w_empty;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed plus randomized bench for psum_accumulator; a queue-based group-sum
// model predicts every output and handshake each cycle.
module tb_psum_accumulator;

  localparam int NP    = 4;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               clear = 1'b0;
  logic               relu_en = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_psum = '0;
  logic signed [15:0] in_bias = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] out_data;
  logic [11:0]        out_addr;
  logic               busy;
  logic               ovf;

  psum_accumulator #(
    .DATA_W(16), .ACC_W(24), .NUM_PASS(NP), .FIFO_DEPTH(DEPTH), .ADDR_W(12)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum), .in_bias(in_bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [27:0] exp_q[$];
  int          grp_cnt = 0;
  int          grp_sum = 0;
  logic [11:0] addr_m  = '0;
  logic [15:0] last_d  = '0;
  logic [11:0] last_a  = '0;
  bit          ovf_m   = 1'b0;
  bit          known   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] ps, input logic [15:0] bs,
                      input logic rl, input logic ordy, input logic clr, input logic rst);
    logic exp_rdy;
    logic acc;
    logic pop;
    logic [15:0] exp_d;
    logic [11:0] exp_a;
    int fin;
    @(negedge clk);
    in_valid = v; in_psum = ps; in_bias = bs; relu_en = rl;
    out_ready = ordy; clear = clr; reset = rst;
    #1;
    exp_rdy = (exp_q.size() < DEPTH) && !clr && !rst;
    exp_d   = (exp_q.size() > 0) ? exp_q[0][27:12] : last_d;
    exp_a   = (exp_q.size() > 0) ? exp_q[0][11:0]  : last_a;
    if (known || rst) chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    if (known) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() > 0});
      chk("out_data", {16'b0, out_data}, {16'b0, exp_d});
      chk("out_addr", {20'b0, out_addr}, {20'b0, exp_a});
      chk("busy", {31'b0, busy}, {31'b0, (grp_cnt != 0) || (exp_q.size() > 0)});
      chk("ovf", {31'b0, ovf}, {31'b0, ovf_m});
    end
    acc = v && exp_rdy;
    pop = (exp_q.size() > 0) && ordy;
    @(posedge clk);
    if (rst || clr) begin
      exp_q.delete();
      grp_cnt = 0; grp_sum = 0; addr_m = '0;
      last_d = '0; last_a = '0; ovf_m = 1'b0; known = 1'b1;
    end else begin
      if (pop) begin
        last_d = exp_q[0][27:12];
        last_a = exp_q[0][11:0];
        void'(exp_q.pop_front());
      end
      if (acc) begin
        if (grp_cnt == 0) grp_sum = $signed(bs);
        grp_sum += $signed(ps);
        grp_cnt++;
        if (grp_cnt == NP) begin
          fin = grp_sum;
          if (rl && fin < 0) fin = 0;
          if (fin > 32767) begin fin = 32767; ovf_m = 1'b1; end
          else if (fin < -32768) begin fin = -32768; ovf_m = 1'b1; end
          exp_q.push_back({fin[15:0], addr_m});
          addr_m++;
          grp_cnt = 0;
        end
      end
    end
  endtask

  task automatic group(input logic [15:0] bs, input logic [15:0] p0, input logic [15:0] p1,
                       input logic [15:0] p2, input logic [15:0] p3, input logic rl,
                       input logic ordy);
    step(1'b1, p0, bs, rl, ordy, 1'b0, 1'b0);
    step(1'b1, p1, bs, rl, ordy, 1'b0, 1'b0);
    step(1'b1, p2, bs, rl, ordy, 1'b0, 1'b0);
    step(1'b1, p3, bs, rl, ordy, 1'b0, 1'b0);
  endtask

  task automatic expect_head(input string tag, input logic [15:0] d, input logic [11:0] a);
    #2;
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_data"}, {16'b0, out_data}, {16'b0, d});
    chk({tag, "_addr"}, {20'b0, out_addr}, {20'b0, a});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] rp;
    logic [15:0] rb;
    // Reset state
    step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_data", {16'b0, out_data}, 32'd0);

    // 1: basic group
    group(16'd10, 16'd100, 16'd200, -16'sd50, 16'd25, 1'b0, 1'b1);
    expect_head("t1", 16'd285, 12'd0);
    chk("t1_ovf", {31'b0, ovf}, 32'd0);
    idle(2);

    // 2: ReLU on then off
    step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    group(16'd0, -16'sd100, -16'sd1, -16'sd1, -16'sd1, 1'b1, 1'b1);
    expect_head("t2_relu", 16'd0, 12'd0);
    group(16'd0, -16'sd100, -16'sd1, -16'sd1, -16'sd1, 1'b0, 1'b1);
    expect_head("t2_norelu", -16'sd103, 12'd1);
    chk("t2_ovf", {31'b0, ovf}, 32'd0);
    idle(2);

    // 3: positive and negative saturation
    group(16'd32767, 16'd32767, 16'd32767, 16'd32767, 16'd32767, 1'b0, 1'b1);
    expect_head("t3_pos", 16'h7fff, 12'd2);
    chk("t3_pos_ovf", {31'b0, ovf}, 32'd1);
    step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    group(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 1'b0, 1'b1);
    expect_head("t3_neg", 16'h8000, 12'd0);
    chk("t3_neg_ovf", {31'b0, ovf}, 32'd1);
    idle(2);

    // 4: backpressure fills the FIFO, then drain
    step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 18; i++) step(1'b1, 16'(i * 7), 16'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("t4_full_ready", {31'b0, in_ready}, 32'd0);
    chk("t4_head_addr", {20'b0, out_addr}, 32'd0);
    step(1'b1, 16'd5, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    chk("t4_ready_back", {31'b0, in_ready}, 32'd1);
    chk("t4_addr1", {20'b0, out_addr}, 32'd1);
    for (int i = 0; i < 6; i++) step(1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // 5: reset aborts a partial group
    step(1'b1, 16'd900, 16'd77, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'd900, 16'd77, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'd900, 16'd77, 1'b0, 1'b1, 1'b0, 1'b1);
    group(16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 1'b0, 1'b1);
    expect_head("t5", 16'd5, 12'd0);
    idle(2);

    // 6: clear with two entries queued and a beat offered
    group(16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 1'b0, 1'b0);
    group(16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 1'b0, 1'b0);
    step(1'b1, 16'd40, 16'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    chk("t6_busy", {31'b0, busy}, 32'd0);
    chk("t6_valid", {31'b0, out_valid}, 32'd0);
    group(16'd4, 16'd4, 16'd4, 16'd4, 16'd4, 1'b0, 1'b1);
    expect_head("t6", 16'd20, 12'd0);

    // Randomized traffic with occasional clears and extreme values
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) rp = 16'($urandom_range(0, 65535));
      else rp = 16'($urandom_range(0, 2000)) - 16'd1000;
      if ($urandom_range(0, 5) == 0) rb = 16'($urandom_range(0, 65535));
      else rb = 16'($urandom_range(0, 200)) - 16'd100;
      step($urandom_range(0, 3) != 0, rp, rb, 1'($urandom_range(0, 1)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 80) == 0, 1'b0);
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
